beltwarn_controller: RTL and testbench

BELTWARN_CONTROLLER -- requirements
Module: beltwarn_controller

---
 rtl/beltwarn_pkg.sv | 18 +
 rtl/beltwarn_tick_counter.sv | 30 +++
 rtl/beltwarn_controller.sv | 139 +++++++++++++
 tb/tb_beltwarn_controller.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/beltwarn_pkg.sv
// Shared types and defaults for the seatbelt warning controller.
// Holds the FSM state encoding, counter width and the default tick counts.
package beltwarn_pkg;

    localparam int unsigned CNT_W              = 4;
    localparam int unsigned WARN_W             = 4;
    localparam int unsigned WARN_MAX           = 15;
    localparam int unsigned DEBOUNCE_TICKS_DEF = 2;
    localparam int unsigned CHIME_TICKS_DEF    = 6;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_DEBOUNCE = 2'b01,
        ST_CHIME    = 2'b10,
        ST_LAMP     = 2'b11
    } state_e;

endpackage

// File: rtl/beltwarn_tick_counter.sv
// Tick counter for the debounce and chime phases.
// Sync clear has priority over the tick enable. o_eq_c flags the tick that reaches i_target.
module beltwarn_tick_counter
    import beltwarn_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_target,
    output logic             o_eq_c
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign o_eq_c    = i_en & (w_cnt_inc == i_target);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_cnt_inc;
        end
    end

endmodule

// File: rtl/beltwarn_controller.sv
// Seatbelt warning controller: debounce the unbuckled condition, chime with a
// blinking lamp for a fixed number of ticks, then hold the lamp on steadily.
module beltwarn_controller
    import beltwarn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF,
    parameter int unsigned CHIME_TICKS    = CHIME_TICKS_DEF
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              K,
    input  logic              P,
    input  logic              S,
    input  logic              Tick,
    output logic              W,
    output logic              Chime,
    output logic [1:0]        State,
    output logic [WARN_W-1:0] Warn_cnt
);

    state_e             r_state;
    state_e             w_state_nxt;
    logic               r_blink;
    logic               w_blink_nxt;
    logic               r_w;
    logic               r_chime;
    logic               w_w_nxt;
    logic               w_chime_nxt;
    logic [WARN_W-1:0]  r_warn_cnt;
    logic               w_warn_inc;
    logic               w_cond;
    logic               w_cnt_en;
    logic               w_cnt_clr;
    logic               w_tick_eq;
    logic [CNT_W-1:0]   w_target;

    assign w_cond    = K & P & ~S;
    assign w_cnt_en  = Tick & ((r_state == ST_DEBOUNCE) || (r_state == ST_CHIME));
    assign w_target  = (r_state == ST_DEBOUNCE) ? CNT_W'(DEBOUNCE_TICKS) : CNT_W'(CHIME_TICKS);
    // Counter restarts on every phase change and whenever the condition drops.
    assign w_cnt_clr = ~w_cond | w_tick_eq | (r_state == ST_IDLE) | (r_state == ST_LAMP);

    beltwarn_tick_counter u_tick_cnt (
        .clk      (Clk),
        .rst_n    (Rst_n),
        .i_clr    (w_cnt_clr),
        .i_en     (w_cnt_en),
        .i_target (w_target),
        .o_eq_c   (w_tick_eq)
    );

    // State register
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, blink and episode-count decisions; a dropped condition wins over Tick
    always_comb begin
        w_state_nxt = r_state;
        w_blink_nxt = r_blink;
        w_warn_inc  = 1'b0;
        if (!w_cond) begin
            w_state_nxt = ST_IDLE;
            w_blink_nxt = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_DEBOUNCE;
                end
                ST_DEBOUNCE: begin
                    if (w_tick_eq) begin
                        w_state_nxt = ST_CHIME;
                        w_blink_nxt = 1'b0;
                        w_warn_inc  = 1'b1;
                    end
                end
                ST_CHIME: begin
                    if (Tick) begin
                        w_blink_nxt = ~r_blink;
                        if (w_tick_eq) begin
                            w_state_nxt = ST_LAMP;
                        end
                    end
                end
                ST_LAMP: begin
                    w_state_nxt = ST_LAMP;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Output decode from the upcoming state so the registered outputs track State
    always_comb begin
        w_w_nxt     = 1'b0;
        w_chime_nxt = 1'b0;
        case (w_state_nxt)
            ST_CHIME: begin
                w_chime_nxt = 1'b1;
                w_w_nxt     = w_blink_nxt;
            end
            ST_LAMP: begin
                w_w_nxt     = 1'b1;
            end
            default: begin
                w_w_nxt     = 1'b0;
                w_chime_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_blink    <= 1'b0;
            r_w        <= 1'b0;
            r_chime    <= 1'b0;
            r_warn_cnt <= '0;
        end else begin
            r_blink <= w_blink_nxt;
            r_w     <= w_w_nxt;
            r_chime <= w_chime_nxt;
            if (w_warn_inc && (r_warn_cnt != WARN_W'(WARN_MAX))) begin
                r_warn_cnt <= r_warn_cnt + WARN_W'(1);
            end
        end
    end

    assign W        = r_w;
    assign Chime    = r_chime;
    assign State    = r_state;
    assign Warn_cnt = r_warn_cnt;

endmodule

// File: tb/tb_beltwarn_controller.sv
// Self-checking bench for beltwarn_controller: directed scenarios plus random
// stimulus, checked against a tick-count model of the warning sequence.
module tb_beltwarn_controller;

    localparam int DB = 2;
    localparam int CH = 4;

    logic       Clk = 1'b0;
    logic       Rst_n;
    logic       K;
    logic       P;
    logic       S;
    logic       Tick;
    logic       W;
    logic       Chime;
    logic [1:0] State;
    logic [3:0] Warn_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // Model: ticks counted since the condition became (and stayed) true
    bit m_in_seq;
    int m_tc;
    int m_eps;

    always #5 Clk = ~Clk;

    beltwarn_controller #(
        .DEBOUNCE_TICKS (DB),
        .CHIME_TICKS    (CH)
    ) dut (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .K        (K),
        .P        (P),
        .S        (S),
        .Tick     (Tick),
        .W        (W),
        .Chime    (Chime),
        .State    (State),
        .Warn_cnt (Warn_cnt)
    );

    function automatic logic [1:0] exp_state();
        if (!m_in_seq)      return 2'd0;
        if (m_tc < DB)      return 2'd1;
        if (m_tc < DB + CH) return 2'd2;
        return 2'd3;
    endfunction

    function automatic logic exp_w();
        if (!m_in_seq || m_tc < DB) return 1'b0;
        if (m_tc >= DB + CH)        return 1'b1;
        return ((m_tc - DB) % 2) == 1;
    endfunction

    function automatic logic exp_chime();
        return m_in_seq && (m_tc >= DB) && (m_tc < DB + CH);
    endfunction

    function automatic logic [3:0] exp_cnt();
        return (m_eps > 15) ? 4'd15 : 4'(m_eps);
    endfunction

    task automatic model_edge(input logic k, input logic p, input logic s, input logic t);
        if (!(k & p & ~s)) begin
            m_in_seq = 1'b0;
            m_tc     = 0;
        end else if (!m_in_seq) begin
            m_in_seq = 1'b1;
            m_tc     = 0;
        end else if (t && m_tc < DB + CH) begin
            m_tc++;
            if (m_tc == DB) m_eps++;
        end
    endtask

    task automatic step(input logic k, input logic p, input logic s, input logic t);
        K = k; P = p; S = s; Tick = t;
        @(posedge Clk);
        model_edge(k, p, s, t);
        #1;
    endtask

    task automatic do_reset();
        Rst_n = 1'b0;
        K = 1'b0; P = 1'b0; S = 1'b0; Tick = 1'b0;
        m_in_seq = 1'b0; m_tc = 0; m_eps = 0;
        repeat (2) @(posedge Clk);
        #1;
        Rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({State, W, Chime, Warn_cnt} !== 8'h00) begin
            n_err++;
            $display("FAIL reset_state got st=%0d w=%b ch=%b cnt=%0d exp all 0", State, W, Chime, Warn_cnt);
        end
        step(1'b1, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (State !== 2'd1) begin
            n_err++;
            $display("FAIL reset_first_exit got st=%0d exp 1", State);
        end
    endtask

    task automatic test_full_sequence();
        do_reset();
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b1, 1'b0, (i % 4) == 3);
            n_cmp++;
            if ({State, W, Chime, Warn_cnt} !== {exp_state(), exp_w(), exp_chime(), exp_cnt()}) begin
                n_err++;
                $display("FAIL full_seq i=%0d got st=%0d w=%b ch=%b cnt=%0d exp st=%0d w=%b ch=%b cnt=%0d",
                         i, State, W, Chime, Warn_cnt, exp_state(), exp_w(), exp_chime(), exp_cnt());
            end
        end
        n_cmp++;
        if ({State, W, Chime, Warn_cnt} !== {2'd3, 1'b1, 1'b0, 4'd1}) begin
            n_err++;
            $display("FAIL full_seq_end got st=%0d w=%b ch=%b cnt=%0d exp st=3 w=1 ch=0 cnt=1",
                     State, W, Chime, Warn_cnt);
        end
    endtask

    task automatic test_debounce_abort();
        bit saw_chime;
        saw_chime = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 1'b0, i == 3);
            saw_chime |= Chime;
        end
        step(1'b1, 1'b1, 1'b1, 1'b0);
        n_cmp++;
        if ({State, W} !== {2'd0, 1'b0}) begin
            n_err++;
            $display("FAIL debounce_abort got st=%0d w=%b exp st=0 w=0", State, W);
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, 1'b1, (i % 4) == 3);
            saw_chime |= Chime;
            n_cmp++;
            if ({State, W, Chime, Warn_cnt} !== {exp_state(), exp_w(), exp_chime(), exp_cnt()}) begin
                n_err++;
                $display("FAIL debounce_hold i=%0d got st=%0d w=%b ch=%b cnt=%0d exp st=%0d w=%b ch=%b cnt=%0d",
                         i, State, W, Chime, Warn_cnt, exp_state(), exp_w(), exp_chime(), exp_cnt());
            end
        end
        n_cmp++;
        if ({saw_chime, Warn_cnt} !== {1'b0, 4'd0}) begin
            n_err++;
            $display("FAIL debounce_no_chime got saw_chime=%b cnt=%0d exp 0 and 0", saw_chime, Warn_cnt);
        end
    endtask

    task automatic test_drop_in_chime();
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, i != 0);
        n_cmp++;
        if ({State, W, Chime} !== {2'd2, 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL drop_pre_chime got st=%0d w=%b ch=%b exp st=2 w=1 ch=1", State, W, Chime);
        end
        step(1'b0, 1'b1, 1'b0, 1'b1);
        n_cmp++;
        if ({State, W, Chime, dut.u_tick_cnt.r_cnt} !== {2'd0, 1'b0, 1'b0, 4'd0}) begin
            n_err++;
            $display("FAIL drop_in_chime got st=%0d w=%b ch=%b tick_cnt=%0d exp all 0",
                     State, W, Chime, dut.u_tick_cnt.r_cnt);
        end
    endtask

    task automatic test_rebuckle();
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
        n_cmp++;
        if ({State, Warn_cnt} !== {2'd3, 4'd1}) begin
            n_err++;
            $display("FAIL rebuckle_lamp got st=%0d cnt=%0d exp st=3 cnt=1", State, Warn_cnt);
        end
        step(1'b1, 1'b1, 1'b1, 1'b0);
        n_cmp++;
        if ({State, W, Chime} !== {2'd0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL rebuckle_idle got st=%0d w=%b ch=%b exp st=0 w=0 ch=0", State, W, Chime);
        end
        for (int i = 0; i < 30; i++) begin
            step(1'b1, 1'b1, 1'b0, (i % 4) == 2);
            n_cmp++;
            if ({State, W, Chime, Warn_cnt} !== {exp_state(), exp_w(), exp_chime(), exp_cnt()}) begin
                n_err++;
                $display("FAIL rebuckle_seq i=%0d got st=%0d w=%b ch=%b cnt=%0d exp st=%0d w=%b ch=%b cnt=%0d",
                         i, State, W, Chime, Warn_cnt, exp_state(), exp_w(), exp_chime(), exp_cnt());
            end
        end
        n_cmp++;
        if ({State, Warn_cnt} !== {2'd3, 4'd2}) begin
            n_err++;
            $display("FAIL rebuckle_end got st=%0d cnt=%0d exp st=3 cnt=2", State, Warn_cnt);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int ep = 0; ep < 17; ep++) begin
            for (int i = 0; i < 10; i++) begin
                step(1'b1, 1'b1, 1'b0, 1'b1);
                n_cmp++;
                if ({State, W, Chime, Warn_cnt} !== {exp_state(), exp_w(), exp_chime(), exp_cnt()}) begin
                    n_err++;
                    $display("FAIL saturate ep=%0d i=%0d got st=%0d w=%b ch=%b cnt=%0d exp st=%0d w=%b ch=%b cnt=%0d",
                             ep, i, State, W, Chime, Warn_cnt, exp_state(), exp_w(), exp_chime(), exp_cnt());
                end
            end
            step(1'b1, 1'b1, 1'b1, 1'b1);
        end
        n_cmp++;
        if (Warn_cnt !== 4'd15) begin
            n_err++;
            $display("FAIL saturate_end got cnt=%0d exp 15", Warn_cnt);
        end
    endtask

    task automatic test_random();
        logic k, p, s, t;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            k = $urandom_range(0, 19) != 0;
            p = $urandom_range(0, 19) != 0;
            s = $urandom_range(0, 24) == 0;
            t = $urandom_range(0, 2) == 0;
            step(k, p, s, t);
            n_cmp++;
            if ({State, W, Chime, Warn_cnt} !== {exp_state(), exp_w(), exp_chime(), exp_cnt()}) begin
                n_err++;
                $display("FAIL random i=%0d got st=%0d w=%b ch=%b cnt=%0d exp st=%0d w=%b ch=%b cnt=%0d",
                         i, State, W, Chime, Warn_cnt, exp_state(), exp_w(), exp_chime(), exp_cnt());
            end
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, i != 0);
        n_cmp++;
        if ({State, Chime, Warn_cnt} !== {2'd2, 1'b1, 4'd1}) begin
            n_err++;
            $display("FAIL midreset_pre got st=%0d ch=%b cnt=%0d exp st=2 ch=1 cnt=1", State, Chime, Warn_cnt);
        end
        #2;
        Rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({State, W, Chime, Warn_cnt} !== 8'h00) begin
            n_err++;
            $display("FAIL midreset_async got st=%0d w=%b ch=%b cnt=%0d exp all 0", State, W, Chime, Warn_cnt);
        end
        m_in_seq = 1'b0; m_tc = 0; m_eps = 0;
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        step(1'b1, 1'b1, 1'b0, 1'b1);
        n_cmp++;
        if ({State, W, Chime, Warn_cnt} !== {exp_state(), exp_w(), exp_chime(), exp_cnt()}) begin
            n_err++;
            $display("FAIL midreset_restart got st=%0d w=%b ch=%b cnt=%0d exp st=%0d w=%b ch=%b cnt=%0d",
                     State, W, Chime, Warn_cnt, exp_state(), exp_w(), exp_chime(), exp_cnt());
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Rst_n = 1'b0;
        K = 1'b0; P = 1'b0; S = 1'b0; Tick = 1'b0;
        test_reset();
        test_full_sequence();
        test_debounce_abort();
        test_drop_in_chime();
        test_rebuckle();
        test_saturation();
        test_random();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
